// File: rtl/riscv_pkg.sv
// Shared loader types and sizing constants, also used by the core top.
package riscv_pkg;

  localparam int unsigned ROMDEPTH   = 256;
  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTEW      = 8;
  localparam int unsigned WORDW      = 32;
  localparam int unsigned LENW       = 16;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Assembles little-endian bytes into a 32-bit word; word_valid_c pulses with the 4th byte.
module byte_packer
  import riscv_pkg::*;
(
  input  logic             clock,
  input  logic             nreset,
  input  logic             clear,
  input  logic             byte_valid,
  input  logic [BYTEW-1:0] byte_in,
  output logic             word_valid_c,
  output logic [WORDW-1:0] word_c
);

  localparam int unsigned BCW   = $clog2(WORD_BYTES);
  localparam int unsigned LANEW = WORDW - BYTEW;

  logic [BCW-1:0]   byte_cnt;
  logic [LANEW-1:0] lanes;

  // Lane index and the three low bytes of the word in progress.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + BCW'(1);
      case (byte_cnt)
        BCW'(0): lanes[7:0]   <= byte_in;
        BCW'(1): lanes[15:8]  <= byte_in;
        BCW'(2): lanes[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  // The top byte completes the word without waiting for a register stage.
  assign word_valid_c = byte_valid && (byte_cnt == BCW'(WORD_BYTES - 1));
  assign word_c       = {byte_in, lanes};

endmodule

// File: rtl/boot_loader.sv
// Loads a checksummed byte image into instruction memory, then releases the core.
module boot_loader
  import riscv_pkg::*;
#(
  parameter int unsigned ROMDEPTH = riscv_pkg::ROMDEPTH,
  parameter int unsigned ADDRW    = $clog2(ROMDEPTH)
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic [BYTEW-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic             restart,
  output logic             imem_we,
  output logic [ADDRW-1:0] imem_addr,
  output logic [WORDW-1:0] imem_wdata,
  output logic             core_nreset,
  output logic [LENW-1:0]  program_len,
  output logic             done,
  output logic             error
);

  loader_state_t    state_q, state_d;
  logic [LENW-1:0]  len_q;
  logic [BYTEW-1:0] sum_q;
  logic [ADDRW-1:0] word_cnt_q;

  logic             accept_c;
  logic             pack_valid_c;
  logic             pack_clear_c;
  logic             word_valid_c;
  logic [WORDW-1:0] word_c;
  logic [LENW-1:0]  len_full_c;
  logic             last_word_c;
  logic [BYTEW-1:0] sum_next_c;

  assign accept_c     = rx_valid && rx_ready;
  assign pack_valid_c = accept_c && (state_q == S_DATA);
  assign pack_clear_c = accept_c && (state_q == S_LEN1);
  assign len_full_c   = {rx_data, len_q[7:0]};
  assign last_word_c  = (LENW'(word_cnt_q) == (len_q - LENW'(1)));
  assign sum_next_c   = BYTEW'(sum_q + rx_data);

  byte_packer u_packer (
    .clock        (clock),
    .nreset       (nreset),
    .clear        (pack_clear_c),
    .byte_valid   (pack_valid_c),
    .byte_in      (rx_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // State register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state_q <= S_LEN0;
    else         state_q <= state_d;
  end

  // Next-state logic: header, payload, checksum, then park in RUN or ERR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN0: if (accept_c) state_d = S_LEN1;
      S_LEN1: begin
        if (accept_c) begin
          if (len_full_c > LENW'(ROMDEPTH)) state_d = S_ERR;
          else if (len_full_c == '0)        state_d = S_CSUM;
          else                              state_d = S_DATA;
        end
      end
      S_DATA: if (word_valid_c && last_word_c) state_d = S_CSUM;
      S_CSUM: begin
        if (accept_c) state_d = (sum_next_c == '0) ? S_RUN : S_ERR;
      end
      S_RUN, S_ERR: if (restart) state_d = S_LEN0;
      default: state_d = S_LEN0;
    endcase
  end

  // Length capture, running checksum and word address counter.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      len_q      <= '0;
      sum_q      <= '0;
      word_cnt_q <= '0;
    end else if (accept_c) begin
      sum_q <= (state_q == S_LEN0) ? rx_data : sum_next_c;
      case (state_q)
        S_LEN0: len_q[7:0]  <= rx_data;
        S_LEN1: begin
          len_q[15:8] <= rx_data;
          word_cnt_q  <= '0;
        end
        S_DATA: if (word_valid_c) word_cnt_q <= word_cnt_q + ADDRW'(1);
        default: ;
      endcase
    end
  end

  // Registered outputs; core_nreset lags RUN entry by one cycle.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rx_ready    <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_nreset <= 1'b0;
      program_len <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      rx_ready    <= (state_d != S_RUN) && (state_d != S_ERR);
      imem_we     <= word_valid_c;
      if (word_valid_c) begin
        imem_addr  <= word_cnt_q;
        imem_wdata <= word_c;
      end
      core_nreset <= (state_q == S_RUN) && (state_d == S_RUN);
      program_len <= (state_d == S_RUN) ? len_q : '0;
      done        <= (state_d == S_RUN);
      error       <= (state_d == S_ERR);
    end
  end

endmodule
